// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Brief    : Dynamic branch predictor built from a table of 2-bit saturating
//            counters. Bimodal (PC-indexed) when GHR_BITS = 0, gshare
//            (PC XOR global history) otherwise. Predicts in Decode, trains
//            from Memory-stage resolution, and keeps running statistics.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int          PHT_DEPTH  = 64,
  parameter int          GHR_BITS   = 0,
  parameter logic [1:0]  INIT_STATE = 2'b01,
  localparam int         IDX_W      = $clog2(PHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pcD,
  input  logic             branchD,
  output logic             pred_takeD,
  output logic [IDX_W-1:0] pred_idxD,
  input  logic             update_en,
  input  logic [IDX_W-1:0] update_idx,
  input  logic             update_pred,
  input  logic             update_taken,
  output logic             mispredictM,
  output logic [31:0]      branch_cnt,
  output logic [31:0]      miss_cnt
);

  localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

  logic [1:0]       r_pht [PHT_DEPTH];
  logic [IDX_W-1:0] w_hist;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_cur;
  logic [1:0]       w_next;
  logic             w_miss;
  logic [31:0]      r_branch_cnt;
  logic [31:0]      r_miss_cnt;
  logic             w_unused_pc;

  // Only the word-index bits of the PC select a counter.
  assign w_unused_pc = ^{pcD[31:IDX_W+2], pcD[1:0]};

  if (GHR_BITS > 0) begin : g_gshare
    logic [GHR_BITS-1:0] r_ghr;

    // Non-speculative global history: shifted in only on resolution.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_ghr <= '0;
      end else if (update_en) begin
        r_ghr <= GHR_BITS'({r_ghr, update_taken});
      end
    end

    assign w_hist = IDX_W'(r_ghr);
  end else begin : g_bimodal
    assign w_hist = '0;
  end

  assign w_idx      = pcD[IDX_W+1:2] ^ w_hist;
  assign pred_idxD  = w_idx;
  assign pred_takeD = branchD & r_pht[w_idx][1];

  assign w_miss      = update_pred ^ update_taken;
  assign mispredictM = update_en & w_miss;

  assign w_cur = r_pht[update_idx];

  // Saturating step of the counter being trained.
  always_comb begin
    w_next = w_cur;
    if (update_taken) begin
      if (w_cur != 2'b11) w_next = w_cur + 2'b01;
    end else begin
      if (w_cur != 2'b00) w_next = w_cur - 2'b01;
    end
  end

  // Counter table: whole-table reset in one cycle, reset beats a same-cycle update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_DEPTH; i++) begin
        r_pht[i] <= INIT_STATE;
      end
    end else if (update_en) begin
      r_pht[update_idx] <= w_next;
    end
  end

  // Statistics counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt <= '0;
      r_miss_cnt   <= '0;
    end else if (update_en) begin
      if (r_branch_cnt != c_CNT_MAX) r_branch_cnt <= r_branch_cnt + 32'd1;
      if (w_miss && (r_miss_cnt != c_CNT_MAX)) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign branch_cnt = r_branch_cnt;
  assign miss_cnt   = r_miss_cnt;

endmodule
`default_nettype wire
